// File: rtl/rv_mem_pkg.sv
// Shared load/store definitions: funct3 encodings, sequencer states and legality helper.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Stores have no unsigned variants, so BU/HU are legal only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/replication, alignment check, load extraction.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_is_store,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_fault,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic        misaligned;
    logic [31:0] shifted;

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        misaligned = 1'b0;
        // funct3[1:0] encodes the access size for both signed and unsigned forms
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be       = 4'b0011 << i_off;
                o_wdata    = {2{i_wdata[15:0]}};
                misaligned = i_off[0];
            end
            default: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                misaligned = (i_off != 2'b00);
            end
        endcase
        o_fault = misaligned || !f3_legal(i_funct3, i_is_store);
    end

    always_comb begin
        shifted = i_rdata >> {i_ld_off, 3'b000};
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    o_ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   o_ld_data = {24'h0, shifted[7:0]};
            F3_HU:   o_ld_data = {16'h0, shifted[15:0]};
            default: o_ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: turns a decoded memory command into one req/ack transaction,
// stalling the pipeline until it completes, with misalignment and timeout faults.
module mem_access_ctrl
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic              o_bus_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic              cmd;
    logic              is_store;
    logic              fault;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       ld_data;

    // A simultaneous read+write is treated as a store.
    assign cmd      = i_MemRead | i_MemWrite;
    assign is_store = i_MemWrite;

    mem_lane_align u_align (
        .i_funct3    (i_funct3),
        .i_off       (i_addr[1:0]),
        .i_is_store  (is_store),
        .i_wdata     (i_wdata),
        .o_be        (lane_be),
        .o_wdata     (lane_wdata),
        .o_fault     (fault),
        .i_ld_funct3 (ld_f3_q),
        .i_ld_off    (ld_off_q),
        .i_rdata     (i_mem_rdata),
        .o_ld_data   (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        ld_f3_d      = ld_f3_q;
        ld_off_d     = ld_off_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd) begin
                    if (fault) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wdata;
                        ld_f3_d     = i_funct3;
                        ld_off_d    = i_addr[1:0];
                    end
                end
            end
            ST_ACCESS: begin
                if (i_mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = ld_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // cnt_q counts completed request cycles; this is the last allowed one.
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign o_stall      = ((state_q == ST_IDLE) && cmd) || (state_q == ST_ACCESS);
    assign o_done       = done_q;
    assign o_rdata      = rdata_q;
    assign o_misaligned = misaligned_q;
    assign o_bus_err    = bus_err_q;
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_be     = mem_be_q;
    assign o_mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, timeout/reset sequences, randomized traffic.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, mis, berr;
    logic [31:0] rdata;
    logic        req, we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_MemRead    (mem_read),
        .i_MemWrite   (mem_write),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_misaligned (mis),
        .o_bus_err    (berr),
        .o_mem_req    (req),
        .o_mem_we     (we),
        .o_mem_addr   (maddr),
        .o_mem_be     (be),
        .o_mem_wdata  (mwdata),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mdata;
        int          ack_at;
    } txn_t;

    typedef struct {
        int          done_cyc;
        logic        mis, berr;
        logic [31:0] rdata;
        int          req_cnt;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] stall_mask;
    } exp_t;

    typedef struct {
        int          done_cyc, done_cnt, req_cnt, req_first;
        logic        mis, berr, we, flag_leak;
        logic [31:0] rdata, maddr, mwdata, stall_mask;
        logic [3:0]  be;
    } obs_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic txn_t mk_t(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] md, input int ack);
        txn_t t;
        t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a; t.wdata = wd; t.mdata = md; t.ack_at = ack;
        return t;
    endfunction

    function automatic exp_t mk_e(input int dc, input logic m, input logic b, input logic [31:0] rd,
                                  input int rq, input logic w, input logic [31:0] ma,
                                  input logic [3:0] bb, input logic [31:0] wd, input logic [31:0] sm);
        exp_t e;
        e.done_cyc = dc; e.mis = m; e.berr = b; e.rdata = rd; e.req_cnt = rq; e.we = w;
        e.maddr = ma; e.be = bb; e.mwdata = wd; e.stall_mask = sm;
        return e;
    endfunction

    // Reference model from the access rules: size in bytes, legality, lane offset, latency.
    function automatic exp_t model(input txn_t t, input logic [31:0] prev);
        exp_t   e;
        int     nb, off, k;
        bit     legal, fault;
        longint v, full;
        nb    = (t.f3 % 4 == 0) ? 1 : (t.f3 % 4 == 1) ? 2 : 4;
        off   = int'(t.addr % 4);
        legal = t.wr ? (t.f3 <= 2) : (t.f3 <= 2 || t.f3 == 4 || t.f3 == 5);
        fault = !legal || (off % nb != 0);
        e = mk_e(1, 1'b0, 1'b0, prev, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1);
        if (fault) begin
            e.mis = 1'b1;
        end else begin
            e.we    = t.wr;
            e.maddr = t.addr - 32'(off);
            e.be    = 4'(((1 << nb) - 1) << off);
            e.mwdata = (nb == 1) ? (t.wdata % 256) * 32'h01010101 :
                       (nb == 2) ? (t.wdata % 65536) * 32'h00010001 : t.wdata;
            k = (t.ack_at >= 1 && t.ack_at <= TO) ? t.ack_at : TO;
            e.berr       = !(t.ack_at >= 1 && t.ack_at <= TO);
            e.req_cnt    = k;
            e.done_cyc   = k + 1;
            e.stall_mask = 32'((64'd1 << (k + 1)) - 1);
            if (!e.berr && !t.wr) begin
                v = longint'(t.mdata) >> (8 * off);
                if (nb < 4) begin
                    full = longint'(1) << (8 * nb);
                    v = v % full;
                    if (t.f3 < 4 && v >= full / 2) v = v - full;
                end
                e.rdata = 32'(v);
            end
        end
        return e;
    endfunction

    task automatic run_txn(input txn_t t, output obs_t o);
        o = '{default: 0};
        o.done_cyc = -1;
        @(posedge clk);
        #1;
        mem_read = t.rd; mem_write = t.wr; funct3 = t.f3; addr = t.addr; wdata = t.wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall && c < 32) o.stall_mask[c] = 1'b1;
            if ((mis || berr) && !done) o.flag_leak = 1'b1;
            if (req) begin
                if (o.req_cnt == 0) begin
                    o.req_first = c; o.we = we; o.maddr = maddr; o.be = be; o.mwdata = mwdata;
                end
                o.req_cnt++;
                mem_ack   = (t.ack_at != 0) && (o.req_cnt == t.ack_at);
                mem_rdata = mem_ack ? t.mdata : $urandom;
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                o.done_cnt++;
                if (o.done_cyc < 0) begin
                    o.done_cyc = c; o.mis = mis; o.berr = berr; o.rdata = rdata;
                end
                mem_read = 1'b0; mem_write = 1'b0;
            end
            if (o.done_cyc >= 0 && c >= o.done_cyc + 1) break;
        end
        mem_ack = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic compare(input string tag, input txn_t t, input obs_t o, input exp_t e);
        chk({tag, " done_cycle"}, o.done_cyc, e.done_cyc);
        chk({tag, " done_pulses"}, o.done_cnt, 1);
        chk({tag, " misaligned"}, o.mis, e.mis);
        chk({tag, " bus_err"}, o.berr, e.berr);
        chk({tag, " rdata"}, o.rdata, e.rdata);
        chk({tag, " req_cycles"}, o.req_cnt, e.req_cnt);
        chk({tag, " stall_mask"}, o.stall_mask, e.stall_mask);
        chk({tag, " flag_without_done"}, o.flag_leak, 1'b0);
        if (e.req_cnt > 0) begin
            chk({tag, " req_first"}, o.req_first, 1);
            chk({tag, " we"}, o.we, e.we);
            chk({tag, " mem_addr"}, o.maddr, e.maddr);
            chk({tag, " be"}, o.be, e.be);
            if (t.wr) chk({tag, " mem_wdata"}, o.mwdata, e.mwdata);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " stall"}, stall, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " rdata"}, rdata, 32'h0);
        chk({tag, " misaligned"}, mis, 1'b0);
        chk({tag, " bus_err"}, berr, 1'b0);
        chk({tag, " req"}, req, 1'b0);
        chk({tag, " we"}, we, 1'b0);
        chk({tag, " mem_addr"}, maddr, 32'h0);
        chk({tag, " be"}, be, 4'h0);
        chk({tag, " mem_wdata"}, mwdata, 32'h0);
    endtask

    vec_t vecs[$];
    obs_t o;
    exp_t e;
    txn_t t;

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        vecs.push_back('{mk_t(1,0,3'b010,32'h100,32'h0,32'hDEADBEEF,3),
                         mk_e(4,0,0,32'hDEADBEEF,3,0,32'h100,4'hF,32'h0,32'hF)});
        vecs.push_back('{mk_t(0,1,3'b000,32'h103,32'hA5,32'h0,1),
                         mk_e(2,0,0,32'hDEADBEEF,1,1,32'h100,4'h8,32'hA5A5A5A5,32'h3)});
        vecs.push_back('{mk_t(1,0,3'b000,32'h102,32'h0,32'h0080FF00,1),
                         mk_e(2,0,0,32'hFFFFFF80,1,0,32'h100,4'h4,32'h0,32'h3)});
        vecs.push_back('{mk_t(1,0,3'b100,32'h102,32'h0,32'h0080FF00,2),
                         mk_e(3,0,0,32'h00000080,2,0,32'h100,4'h4,32'h0,32'h7)});
        vecs.push_back('{mk_t(1,0,3'b001,32'h100,32'h0,32'h0080FF00,1),
                         mk_e(2,0,0,32'hFFFFFF00,1,0,32'h100,4'h3,32'h0,32'h3)});
        vecs.push_back('{mk_t(1,0,3'b101,32'h100,32'h0,32'h0080FF00,1),
                         mk_e(2,0,0,32'h0000FF00,1,0,32'h100,4'h3,32'h0,32'h3)});
        vecs.push_back('{mk_t(1,0,3'b010,32'h102,32'h0,32'h0,1),
                         mk_e(1,1,0,32'h0000FF00,0,0,32'h0,4'h0,32'h0,32'h1)});
        vecs.push_back('{mk_t(0,1,3'b001,32'h101,32'h0,32'h0,1),
                         mk_e(1,1,0,32'h0000FF00,0,0,32'h0,4'h0,32'h0,32'h1)});
        vecs.push_back('{mk_t(1,0,3'b011,32'h100,32'h0,32'h0,1),
                         mk_e(1,1,0,32'h0000FF00,0,0,32'h0,4'h0,32'h0,32'h1)});
        vecs.push_back('{mk_t(1,1,3'b010,32'h200,32'h12345678,32'h55555555,2),
                         mk_e(3,0,0,32'h0000FF00,2,1,32'h200,4'hF,32'h12345678,32'h7)});
        vecs.push_back('{mk_t(0,1,3'b001,32'h102,32'h0000BEEF,32'h0,1),
                         mk_e(2,0,0,32'h0000FF00,1,1,32'h100,4'hC,32'hBEEFBEEF,32'h3)});
        vecs.push_back('{mk_t(0,1,3'b100,32'h100,32'h0,32'h0,1),
                         mk_e(1,1,0,32'h0000FF00,0,0,32'h0,4'h0,32'h0,32'h1)});
        vecs.push_back('{mk_t(0,1,3'b010,32'h10,32'hCAFEF00D,32'h0,16),
                         mk_e(17,0,0,32'h0000FF00,16,1,32'h10,4'hF,32'hCAFEF00D,32'h1FFFF)});
        vecs.push_back('{mk_t(1,0,3'b001,32'h202,32'h0,32'h7FFF1234,1),
                         mk_e(2,0,0,32'h00007FFF,1,0,32'h200,4'hC,32'h0,32'h3)});

        foreach (vecs[i]) begin
            run_txn(vecs[i].t, o);
            compare($sformatf("vec%0d", i), vecs[i].t, o, vecs[i].e);
        end
        exp_prev = 32'h00007FFF;

        // Store that never gets an ack, then an ack arriving after completion.
        t = mk_t(0, 1, 3'b010, 32'h300, 32'h11223344, 32'h0, 0);
        run_txn(t, o);
        compare("timeout", t, o, mk_e(17,0,1,exp_prev,16,1,32'h300,4'hF,32'h11223344,32'h1FFFF));
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack done", done, 1'b0);
        chk("late_ack req", req, 1'b0);
        chk("late_ack stall", stall, 1'b0);
        chk("late_ack rdata", rdata, exp_prev);

        // Reset asserted in the middle of an access.
        @(posedge clk);
        #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
        repeat (3) @(negedge clk);
        chk("pre_reset req", req, 1'b1);
        #1;
        rst_n = 1'b0; mem_read = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_prev = 32'h0;
        t = mk_t(1, 0, 3'b010, 32'h404, 32'h0, 32'h600DCAFE, 2);
        run_txn(t, o);
        e = model(t, exp_prev);
        compare("post_reset", t, o, e);
        exp_prev = e.rdata;

        for (int i = 0; i < 200; i++) begin
            t.wr    = $urandom_range(0, 1);
            t.rd    = t.wr ? $urandom_range(0, 1) : 1'b1;
            t.f3    = $urandom_range(0, 7);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.mdata = $urandom;
            t.ack_at = $urandom_range(0, 6);
            run_txn(t, o);
            e = model(t, exp_prev);
            compare($sformatf("rand%0d", i), t, o, e);
            exp_prev = e.rdata;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
